warp_state_table: RTL and testbench
===================================

# warp_state_table

Per-warp architectural state for the compute unit: holds the program counter and lifecycle state of NUM_WARPS warps and updates them on launch, scheduler issue and writeback events. It generalises the single-warp PC register to a parametrised table with launch PC, branch redirect, halt/done tracking and illegal-event detection. It sits between the warp scheduler (issue), the readiness check (future_ready) and the writeback stage (completion, branch, halt).

## Interface
- NUM_WARPS, 4, number of warp slots (≥2)
- PC_WIDTH, 8, PC width in bits
- INSTR_BYTES, 2, PC increment per issued instruction
- WID_W, $clog2(NUM_WARPS), warp index width (derived, not overridden)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- launch_valid  in  1  start a warp
- launch_warp  in  WID_W  warp to start
- launch_pc  in  PC_WIDTH  start PC
- issue_valid  in  1  scheduler selected a warp this cycle
- issue_warp  in  WID_W  selected warp
- wb_valid  in  1  an issued instruction completed
- wb_warp  in  WID_W  warp that completed
- wb_branch  in  1  redirect PC to wb_target
- wb_target  in  PC_WIDTH  branch target
- wb_halt  in  1  warp executed halt
- future_ready  in  NUM_WARPS  per-warp operand readiness from readiness check
- pc  out  NUM_WARPS*PC_WIDTH  packed PCs, warp i at [i*PC_WIDTH +: PC_WIDTH]
- ready  out  NUM_WARPS  warp may be issued this cycle
- done  out  NUM_WARPS  warp halted
- all_done  out  1  every launched warp has halted and none running
- err  out  1  one-cycle pulse: previous cycle carried an ignored event

## Operation
- Per-warp state: IDLE, READY, BUSY, DONE.
- IDLE or DONE + launch → READY, pc ← launch_pc.
- READY + issue → BUSY, pc ← pc + INSTR_BYTES, modulo 2^PC_WIDTH (wrap silently).
- BUSY + wb → READY; if wb_branch, pc ← wb_target. If wb_halt → DONE, pc unchanged (halt overrides branch).
- Events are legal only in the states above; launch/issue/wb are state-disjoint, so at most one applies per warp per cycle. Events to different warps in the same cycle all apply.
- Illegal event (launch to READY/BUSY, issue to non-READY, wb to non-BUSY, index ≥ NUM_WARPS) → ignored, no state/pc change, err=1 next cycle. Multiple illegal events in one cycle → single err pulse.
- ready[i] = (state==READY) & future_ready[i]; combinational from registered state.
- done[i] = (state==DONE). all_done = no warp READY/BUSY and at least one warp DONE.

## Timing
- Reset: all states IDLE, all pc 0, ready 0, done 0, all_done 0, err 0. Reset mid-operation discards in-flight state in the same edge; events in the reset cycle are ignored and raise no err.
- State/pc updates visible one cycle after the event edge.
- ready reflects future_ready in the same cycle (zero latency), so the scheduler may issue, and the warp drops ready the cycle after issue.
- Minimum issue-to-reissue for one warp: 2 cycles (issue, wb in the next cycle, READY the cycle after).
- err asserted exactly one cycle after the offending event.

## Structure
- Shared package gpu_pkg: warp_state_e enum (IDLE/READY/BUSY/DONE, 2 bits), default PC_WIDTH/NUM_WARPS/INSTR_BYTES constants.
- Sub-module warp_slot: one warp's state+pc with decoded launch/issue/wb strobes, outputs state, pc, illegal flag; instantiated NUM_WARPS times via generate. Top decodes indices, ORs illegal flags into err, reduces all_done.

## Test plan
- Reset, launch warp 2 at 0x10, future_ready=4'b0100 → next cycle ready=4'b0100, pc[2]=0x10; others IDLE, pc 0.
- Issue warp 2, wb warp 2 next cycle, repeat 3× → pc[2]=0x16, ready[2]=1 after final wb; ready[2]=0 in each BUSY cycle.
- Launch warp 1 at 0xFF, issue → pc[1]=0x01 (wrap); wb with wb_branch=1, wb_target=0x40 → pc[1]=0x40, READY.
- Issue warp 0 while IDLE, and wb warp 3 while IDLE → no state change, single err pulse next cycle; illegal launch of a BUSY warp → err, pc unchanged.
- Launch warps 0,1 run to wb_halt (with wb_branch=1) → done=4'b0011, pcs unchanged by branch, all_done=1; relaunch warp 0 → all_done=0.
- Reset asserted while warp 1 BUSY and issue_valid for warp 0 → next cycle all IDLE, pc 0, err 0.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared compute-unit types: per-warp lifecycle encoding and default table sizing.
package gpu_pkg;

  typedef enum logic [1:0] {
    WS_IDLE  = 2'd0,
    WS_READY = 2'd1,
    WS_BUSY  = 2'd2,
    WS_DONE  = 2'd3
  } warp_state_e;

  localparam int unsigned DEF_NUM_WARPS   = 4;
  localparam int unsigned DEF_PC_WIDTH    = 8;
  localparam int unsigned DEF_INSTR_BYTES = 2;

endpackage

// File: rtl/warp_slot.sv
// One warp's lifecycle state and PC, advanced by pre-decoded launch/issue/writeback strobes.
module warp_slot
  import gpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = DEF_PC_WIDTH,
  parameter int unsigned INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                launch_i,
  input  logic [PC_WIDTH-1:0] launch_pc_i,
  input  logic                issue_i,
  input  logic                wb_i,
  input  logic                wb_branch_i,
  input  logic [PC_WIDTH-1:0] wb_target_i,
  input  logic                wb_halt_i,
  output warp_state_e         state_o,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                illegal_o
);

  warp_state_e         state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= WS_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Each event is legal in a disjoint set of states, so at most one of the
  // branches below can update state; the rest only flag as illegal.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    illegal_o = 1'b0;

    if (launch_i) begin
      if (state_q == WS_IDLE || state_q == WS_DONE) begin
        state_d = WS_READY;
        pc_d    = launch_pc_i;
      end else begin
        illegal_o = 1'b1;
      end
    end

    if (issue_i) begin
      if (state_q == WS_READY) begin
        state_d = WS_BUSY;
        pc_d    = pc_q + PC_WIDTH'(INSTR_BYTES);
      end else begin
        illegal_o = 1'b1;
      end
    end

    if (wb_i) begin
      if (state_q == WS_BUSY) begin
        if (wb_halt_i) begin
          state_d = WS_DONE;
        end else begin
          state_d = WS_READY;
          if (wb_branch_i) pc_d = wb_target_i;
        end
      end else begin
        illegal_o = 1'b1;
      end
    end
  end

  assign state_o = state_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/warp_state_table.sv
// Per-warp PC/lifecycle table: decodes event indices to slots, reports readiness,
// completion and a registered pulse for any ignored event.
module warp_state_table
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_WARPS   = DEF_NUM_WARPS,
  parameter int unsigned PC_WIDTH    = DEF_PC_WIDTH,
  parameter int unsigned INSTR_BYTES = DEF_INSTR_BYTES,
  localparam int unsigned WID_W      = $clog2(NUM_WARPS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          launch_valid,
  input  logic [WID_W-1:0]              launch_warp,
  input  logic [PC_WIDTH-1:0]           launch_pc,
  input  logic                          issue_valid,
  input  logic [WID_W-1:0]              issue_warp,
  input  logic                          wb_valid,
  input  logic [WID_W-1:0]              wb_warp,
  input  logic                          wb_branch,
  input  logic [PC_WIDTH-1:0]           wb_target,
  input  logic                          wb_halt,
  input  logic [NUM_WARPS-1:0]          future_ready,
  output logic [NUM_WARPS*PC_WIDTH-1:0] pc,
  output logic [NUM_WARPS-1:0]          ready,
  output logic [NUM_WARPS-1:0]          done,
  output logic                          all_done,
  output logic                          err
);

  localparam logic [WID_W:0] NW = (WID_W + 1)'(NUM_WARPS);

  logic [NUM_WARPS-1:0] slot_illegal;
  logic [NUM_WARPS-1:0] slot_active;
  logic                 range_err;
  logic                 err_q, err_d;

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_slot
    warp_state_e         slot_state;
    logic [PC_WIDTH-1:0] slot_pc;

    warp_slot #(
      .PC_WIDTH   (PC_WIDTH),
      .INSTR_BYTES(INSTR_BYTES)
    ) u_slot (
      .clk_i      (clk),
      .reset_i    (reset),
      .launch_i   (launch_valid && (launch_warp == WID_W'(gi))),
      .launch_pc_i(launch_pc),
      .issue_i    (issue_valid && (issue_warp == WID_W'(gi))),
      .wb_i       (wb_valid && (wb_warp == WID_W'(gi))),
      .wb_branch_i(wb_branch),
      .wb_target_i(wb_target),
      .wb_halt_i  (wb_halt),
      .state_o    (slot_state),
      .pc_o       (slot_pc),
      .illegal_o  (slot_illegal[gi])
    );

    assign pc[gi*PC_WIDTH +: PC_WIDTH] = slot_pc;
    assign ready[gi]       = (slot_state == WS_READY) && future_ready[gi];
    assign done[gi]        = (slot_state == WS_DONE);
    assign slot_active[gi] = (slot_state == WS_READY) || (slot_state == WS_BUSY);
  end

  // Indices past the table (only reachable when NUM_WARPS is not a power of two)
  // match no slot, so they must be flagged here.
  always_comb begin
    range_err = (launch_valid && ({1'b0, launch_warp} >= NW)) ||
                (issue_valid  && ({1'b0, issue_warp}  >= NW)) ||
                (wb_valid     && ({1'b0, wb_warp}     >= NW));
    err_d     = range_err || (|slot_illegal);
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err      = err_q;
  assign all_done = ~(|slot_active) && (|done);

endmodule

// File: tb/tb_warp_state_table.sv
// Directed-vector bench: the driver queues hand-computed expectations, a monitor checks them after each edge.
module tb_warp_state_table;

  localparam int unsigned NW = 4;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          launch_valid, issue_valid, wb_valid;
  logic [1:0]    launch_warp, issue_warp, wb_warp;
  logic [PW-1:0] launch_pc, wb_target;
  logic          wb_branch, wb_halt;
  logic [NW-1:0] future_ready;
  logic [NW*PW-1:0] pc;
  logic [NW-1:0] ready, done;
  logic          all_done, err;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [3:0]  ready;
    logic [3:0]  done;
    logic        all_done;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  warp_state_table #(
    .NUM_WARPS  (4),
    .PC_WIDTH   (8),
    .INSTR_BYTES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .launch_valid(launch_valid),
    .launch_warp (launch_warp),
    .launch_pc   (launch_pc),
    .issue_valid (issue_valid),
    .issue_warp  (issue_warp),
    .wb_valid    (wb_valid),
    .wb_warp     (wb_warp),
    .wb_branch   (wb_branch),
    .wb_target   (wb_target),
    .wb_halt     (wb_halt),
    .future_ready(future_ready),
    .pc          (pc),
    .ready       (ready),
    .done        (done),
    .all_done    (all_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic clear_events();
    launch_valid = 1'b0; launch_warp = '0; launch_pc = '0;
    issue_valid  = 1'b0; issue_warp  = '0;
    wb_valid     = 1'b0; wb_warp     = '0;
    wb_branch    = 1'b0; wb_target   = '0; wb_halt = 1'b0;
  endtask

  // Expectation for the outputs sampled just after the coming rising edge.
  task automatic cyc(input string nm, input logic [31:0] p, input logic [3:0] r,
                     input logic [3:0] d, input logic ad, input logic e);
    exp_t x;
    x.name = nm; x.pc = p; x.ready = r; x.done = d; x.all_done = ad; x.err = e;
    sbq.push_back(x);
    @(negedge clk);
    clear_events();
  endtask

  task automatic launch(input logic [1:0] w, input logic [7:0] p);
    launch_valid = 1'b1; launch_warp = w; launch_pc = p;
  endtask

  task automatic issue(input logic [1:0] w);
    issue_valid = 1'b1; issue_warp = w;
  endtask

  task automatic wb(input logic [1:0] w, input logic br, input logic [7:0] tgt, input logic h);
    wb_valid = 1'b1; wb_warp = w; wb_branch = br; wb_target = tgt; wb_halt = h;
  endtask

  // Monitor: compares every queued expectation against the DUT after each edge.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        tests++;
        if (pc !== x.pc) begin
          fails++;
          $display("FAIL %s pc: got %h expected %h", x.name, pc, x.pc);
        end
        tests++;
        if (ready !== x.ready) begin
          fails++;
          $display("FAIL %s ready: got %b expected %b", x.name, ready, x.ready);
        end
        tests++;
        if (done !== x.done) begin
          fails++;
          $display("FAIL %s done: got %b expected %b", x.name, done, x.done);
        end
        tests++;
        if (all_done !== x.all_done) begin
          fails++;
          $display("FAIL %s all_done: got %b expected %b", x.name, all_done, x.all_done);
        end
        tests++;
        if (err !== x.err) begin
          fails++;
          $display("FAIL %s err: got %b expected %b", x.name, err, x.err);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sbq.size());
    $fatal(1, "timeout");
  end

  initial begin : driver
    clear_events();
    reset = 1'b1;
    future_ready = 4'b0000;
    @(negedge clk);
    cyc("reset0", 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc("reset1", 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    reset = 1'b0;

    future_ready = 4'b0100;
    launch(2'd2, 8'h10);
    cyc("launch_w2", 32'h0010_0000, 4'b0100, 4'b0000, 1'b0, 1'b0);
    issue(2'd2);             cyc("issue_w2_a", 32'h0012_0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    wb(2'd2, 0, 8'h00, 0);   cyc("wb_w2_a",    32'h0012_0000, 4'b0100, 4'b0000, 1'b0, 1'b0);
    issue(2'd2);             cyc("issue_w2_b", 32'h0014_0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    wb(2'd2, 0, 8'h00, 0);   cyc("wb_w2_b",    32'h0014_0000, 4'b0100, 4'b0000, 1'b0, 1'b0);
    issue(2'd2);             cyc("issue_w2_c", 32'h0016_0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    wb(2'd2, 0, 8'h00, 0);   cyc("wb_w2_c",    32'h0016_0000, 4'b0100, 4'b0000, 1'b0, 1'b0);

    future_ready = 4'b0110;
    launch(2'd1, 8'hFF);     cyc("launch_w1_ff", 32'h0016_FF00, 4'b0110, 4'b0000, 1'b0, 1'b0);
    issue(2'd1);             cyc("issue_w1_wrap", 32'h0016_0100, 4'b0100, 4'b0000, 1'b0, 1'b0);
    wb(2'd1, 1, 8'h40, 0);   cyc("wb_w1_branch", 32'h0016_4000, 4'b0110, 4'b0000, 1'b0, 1'b0);

    issue(2'd0);
    wb(2'd3, 0, 8'h00, 0);   cyc("illegal_idle", 32'h0016_4000, 4'b0110, 4'b0000, 1'b0, 1'b1);
    cyc("err_clears", 32'h0016_4000, 4'b0110, 4'b0000, 1'b0, 1'b0);
    issue(2'd1);             cyc("issue_w1", 32'h0016_4200, 4'b0100, 4'b0000, 1'b0, 1'b0);
    launch(2'd1, 8'h99);     cyc("launch_busy", 32'h0016_4200, 4'b0100, 4'b0000, 1'b0, 1'b1);
    wb(2'd1, 0, 8'h00, 0);   cyc("wb_w1_plain", 32'h0016_4200, 4'b0110, 4'b0000, 1'b0, 1'b0);
    issue(2'd1);             cyc("issue_w1_2", 32'h0016_4400, 4'b0100, 4'b0000, 1'b0, 1'b0);

    reset = 1'b1;
    issue(2'd0);             cyc("reset_mid", 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    reset = 1'b0;
    cyc("post_reset", 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

    future_ready = 4'b0011;
    launch(2'd0, 8'h20);     cyc("launch_w0", 32'h0000_0020, 4'b0001, 4'b0000, 1'b0, 1'b0);
    launch(2'd1, 8'h30);
    issue(2'd0);             cyc("launch_w1_issue_w0", 32'h0000_3022, 4'b0010, 4'b0000, 1'b0, 1'b0);
    wb(2'd0, 1, 8'h77, 1);
    issue(2'd1);             cyc("halt_w0_issue_w1", 32'h0000_3222, 4'b0000, 4'b0001, 1'b0, 1'b0);
    wb(2'd1, 1, 8'h55, 1);   cyc("halt_w1", 32'h0000_3222, 4'b0000, 4'b0011, 1'b1, 1'b0);
    cyc("hold_all_done", 32'h0000_3222, 4'b0000, 4'b0011, 1'b1, 1'b0);
    launch(2'd0, 8'h60);     cyc("relaunch_w0", 32'h0000_3260, 4'b0001, 4'b0010, 1'b0, 1'b0);
    issue(2'd1);             cyc("issue_done_w1", 32'h0000_3260, 4'b0001, 4'b0010, 1'b0, 1'b1);
    future_ready = 4'b0000;
    cyc("fr_low", 32'h0000_3260, 4'b0000, 4'b0010, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
